// File: rtl/pe_stg_gen_pkg.sv
// Shared types and arithmetic helpers for the parametrised systolic PE.
// Helpers work on a 64-bit signed scratch width; callers pass the real width.
package pe_stg_gen_pkg;

  typedef enum logic [1:0] {
    MODE_MM   = 2'b00,
    MODE_BYP  = 2'b01,
    MODE_NORM = 2'b10
  } mode_e;

  localparam int CALC_W = 64;

  // Signed add clamped to the range of a w-bit two's complement value.
  function automatic logic signed [CALC_W-1:0] sat_add(
    input logic signed [CALC_W-1:0] a,
    input logic signed [CALC_W-1:0] b,
    input int                       w
  );
    logic signed [CALC_W-1:0] s;
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  // Magnitude of a w-bit signed value; the most-negative code clamps to max.
  function automatic logic signed [CALC_W-1:0] sm_mag(
    input logic signed [CALC_W-1:0] v,
    input int                       w
  );
    logic signed [CALC_W-1:0] m;
    logic signed [CALC_W-1:0] hi;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    m  = (v < 0) ? -v : v;
    if (m > hi) m = hi;
    return m;
  endfunction

endpackage

// File: rtl/pe_fp_norm.sv
// Combinational normalize of a signed double-width product to sign/exp/magnitude.
// Pure logic, no state; the result register lives in the parent PE.
module pe_fp_norm #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 8
) (
  input  logic [2*MAN_W-1:0] prod,
  input  logic [EXP_W-1:0]   exp_in,
  output logic               sign,
  output logic [EXP_W-1:0]   exp_out,
  output logic [MAN_W-2:0]   mag
);
  import pe_stg_gen_pkg::*;

  logic                    flag;
  logic signed [MAN_W-1:0] man;

  always_comb begin
    // Top two bits differ: the product already uses the guard bit, so keep it.
    flag    = prod[2*MAN_W-1] ^ prod[2*MAN_W-2];
    man     = flag ? prod[2*MAN_W-1 -: MAN_W] : prod[2*MAN_W-2 -: MAN_W];
    exp_out = exp_in + EXP_W'(flag);
    sign    = man[MAN_W-1];
    mag     = (MAN_W-1)'(sm_mag(64'(man), MAN_W));
  end

endmodule

// File: rtl/pe_stg_gen.sv
// Weight-stationary PE: east path 1 cycle, acc update 2 cycles after left_in, norm 1 cycle.
// No backpressure: every input is consumed in the cycle it is presented.
module pe_stg_gen #(
  parameter  int ACT_W = 8,
  parameter  int WGT_W = 8,
  parameter  int LANES = 2,
  parameter  int ACC_W = 24,
  parameter  int TOP_W = 48,
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 8,
  localparam int NSLOT = TOP_W / (LANES * WGT_W),
  localparam int SEL_W = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_sel_in,
  input  logic             act_vld_in,
  input  logic [ACT_W-1:0] left_in,
  output logic [ACT_W-1:0] right_out,
  output logic             act_vld_out,
  input  logic             wgt_ld_in,
  input  logic [SEL_W-1:0] wgt_sel_in,
  input  logic             wgt_swap_in,
  input  logic             clr_in,
  input  logic             drain_in,
  input  logic [TOP_W-1:0] top_in,
  output logic [TOP_W-1:0] bottom_out,
  output logic             sat_flag_out
);
  import pe_stg_gen_pkg::*;

  localparam int SLOT_W = LANES * WGT_W;
  localparam int PROD_W = ACT_W + WGT_W;
  localparam int PACK_W = LANES * ACC_W;

  mode_e                    mode;
  logic signed [WGT_W-1:0]  shadow [LANES];
  logic signed [WGT_W-1:0]  active [LANES];
  logic signed [PROD_W-1:0] prod   [LANES];
  logic                     m_vld;
  logic signed [ACC_W-1:0]  acc     [LANES];
  logic signed [ACC_W-1:0]  acc_sum [LANES];
  logic [LANES-1:0]         sat_lane;
  logic [PACK_W-1:0]        acc_pack;
  logic signed [63:0]       wide;
  logic                     n_sign;
  logic [EXP_W-1:0]         n_exp;
  logic [MAN_W-2:0]         n_mag;

  assign mode = mode_e'(mode_sel_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      right_out   <= '0;
      act_vld_out <= 1'b0;
    end else begin
      right_out   <= left_in;
      act_vld_out <= act_vld_in;
    end
  end

  // Swap reads the pre-load shadow, so load+swap in one cycle moves the old slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (wgt_swap_in) active[i] <= shadow[i];
        if (wgt_ld_in)
          shadow[i] <= top_in[int'(wgt_sel_in)*SLOT_W + i*WGT_W +: WGT_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld <= 1'b0;
      for (int i = 0; i < LANES; i++) prod[i] <= '0;
    end else begin
      m_vld <= (mode == MODE_MM) && act_vld_in;
      if ((mode == MODE_MM) && act_vld_in) begin
        for (int i = 0; i < LANES; i++)
          prod[i] <= PROD_W'($signed(left_in)) * PROD_W'(active[i]);
      end
    end
  end

  always_comb begin
    wide     = '0;
    sat_lane = '0;
    acc_pack = '0;
    for (int i = 0; i < LANES; i++) begin
      wide        = sat_add(64'(acc[i]), 64'(prod[i]), ACC_W);
      acc_sum[i]  = ACC_W'(wide);
      sat_lane[i] = (wide != (64'(acc[i]) + 64'(prod[i])));
      acc_pack[i*ACC_W +: ACC_W] = acc[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag_out <= 1'b0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (clr_in) begin
      sat_flag_out <= 1'b0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (drain_in) begin
      for (int i = 0; i < LANES; i++) acc[i] <= top_in[i*ACC_W +: ACC_W];
    end else if (m_vld) begin
      for (int i = 0; i < LANES; i++) acc[i] <= acc_sum[i];
      if (|sat_lane) sat_flag_out <= 1'b1;
    end
  end

  pe_fp_norm #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_norm (
    .prod    (top_in[2*MAN_W-1:0]),
    .exp_in  (top_in[2*MAN_W +: EXP_W]),
    .sign    (n_sign),
    .exp_out (n_exp),
    .mag     (n_mag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     bottom_out <= '0;
    else if (drain_in)           bottom_out <= TOP_W'(acc_pack);
    else if (mode == MODE_NORM)  bottom_out <= TOP_W'({n_sign, n_exp, n_mag});
    else                         bottom_out <= top_in;
  end

endmodule

// File: tb/tb_pe_stg_gen.sv
// Bench for pe_stg_gen: default instance plus a narrow ACC_W=16/TOP_W=32 instance.
module tb_pe_stg_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        act_vld;
  logic [7:0]  left;
  logic        wgt_ld;
  logic [1:0]  wgt_sel;
  logic        swap;
  logic        clr;
  logic        drain;
  logic [47:0] top;
  logic [7:0]  right0, right1;
  logic        avo0, avo1;
  logic [47:0] bot0;
  logic [31:0] bot1;
  logic        sat0, sat1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [47:0] mask;
    logic [47:0] val;
    bit          sel1;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [15:0] w;
    logic [7:0]  a;
    int          n;
    logic [47:0] res;
  } mm_vec_t;

  typedef struct {
    logic [7:0]  e;
    logic [15:0] p;
    logic [15:0] res;
  } nm_vec_t;

  mm_vec_t mm[3];
  nm_vec_t nm[5];

  always #5 clk = ~clk;

  pe_stg_gen u0 (
    .clk(clk), .rst(rst), .mode_sel_in(mode), .act_vld_in(act_vld), .left_in(left),
    .right_out(right0), .act_vld_out(avo0), .wgt_ld_in(wgt_ld), .wgt_sel_in(wgt_sel),
    .wgt_swap_in(swap), .clr_in(clr), .drain_in(drain), .top_in(top),
    .bottom_out(bot0), .sat_flag_out(sat0)
  );

  pe_stg_gen #(.ACC_W(16), .TOP_W(32)) u1 (
    .clk(clk), .rst(rst), .mode_sel_in(mode), .act_vld_in(act_vld), .left_in(left),
    .right_out(right1), .act_vld_out(avo1), .wgt_ld_in(wgt_ld), .wgt_sel_in(wgt_sel[0]),
    .wgt_swap_in(swap), .clr_in(clr), .drain_in(drain), .top_in(top[31:0]),
    .bottom_out(bot1), .sat_flag_out(sat1)
  );

  task automatic chk(input string nm_s, input logic [47:0] got, input logic [47:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm_s, got, want);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (q.size() != 0) begin
      e = q.pop_front();
      chk(e.name, (e.sel1 ? {16'h0, bot1} : bot0) & e.mask, e.val & e.mask);
    end
  endtask

  task automatic load_w(input logic [15:0] w);
    top = {32'h0, w}; wgt_sel = 2'd0; wgt_ld = 1'b1;
    tick();
    wgt_ld = 1'b0; swap = 1'b1;
    tick();
    swap = 1'b0; top = '0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic acts(input logic [7:0] a, input int n);
    act_vld = 1'b1; left = a;
    repeat (n) tick();
    act_vld = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain_exp(input string nm_s, input logic [47:0] t,
                           input logic [47:0] mask, input logic [47:0] val, input bit sel1);
    top = t; drain = 1'b1;
    q.push_back('{nm_s, mask, val, sel1});
    tick();
    drain = 1'b0; top = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    mm[0] = '{16'hFD05, 8'd4,   3, {24'hFFFFDC, 24'd60}};
    mm[1] = '{16'h807F, 8'h80,  2, {24'h008000, 24'hFF8100}};
    mm[2] = '{16'h01FF, 8'h7F,  4, {24'h0001FC, 24'hFFFE04}};
    nm[0] = '{8'h80, 16'h4000, 16'h40C0};
    nm[1] = '{8'h80, 16'h2000, 16'h4040};
    nm[2] = '{8'h80, 16'hC000, 16'hC07F};
    nm[3] = '{8'hFF, 16'h4000, 16'h0040};
    nm[4] = '{8'h10, 16'h8000, 16'h88FF};

    rst = 1'b1; mode = 2'b00; act_vld = 1'b0; left = '0; wgt_ld = 1'b0; wgt_sel = '0;
    swap = 1'b0; clr = 1'b0; drain = 1'b0; top = '0;
    #3;
    chk("rst_bottom", bot0, 48'h0);
    chk("rst_right", {40'h0, right0}, 48'h0);
    chk("rst_avo", {47'h0, avo0}, 48'h0);
    chk("rst_sat", {47'h0, sat0}, 48'h0);
    #5 rst = 1'b0;

    // Matmul vectors: load, clear, stream activations, idle, drain
    for (int k = 0; k < 3; k++) begin
      load_w(mm[k].w);
      do_clr();
      act_vld = 1'b1; left = mm[k].a;
      repeat (mm[k].n) tick();
      chk($sformatf("east_dat%0d", k), {40'h0, right0}, {40'h0, mm[k].a});
      chk($sformatf("east_vld%0d", k), {47'h0, avo0}, 48'h1);
      act_vld = 1'b0;
      tick();
      tick();
      drain_exp($sformatf("mm%0d", k), 48'h0, {48{1'b1}}, mm[k].res, 1'b0);
    end

    // Normalize vectors
    mode = 2'b10;
    for (int k = 0; k < 5; k++) begin
      top = {24'h0, nm[k].e, nm[k].p};
      q.push_back('{$sformatf("norm%0d", k), {48{1'b1}}, {32'h0, nm[k].res}, 1'b0});
      tick();
    end
    mode = 2'b11;
    top = 48'hA5A5_1234_5678;
    q.push_back('{"bypass11", {48{1'b1}}, 48'hA5A5_1234_5678, 1'b0});
    tick();
    mode = 2'b00;

    // Saturation on the narrow instance; wide instance keeps the true sum
    load_w(16'h007F);
    do_clr();
    acts(8'd127, 3);
    chk("sat_flag_set", {47'h0, sat1}, 48'h1);
    chk("sat_flag_wide", {47'h0, sat0}, 48'h0);
    q.push_back('{"wide_nosat", 48'hFFFFFF, 48'h00BD03, 1'b0});
    drain_exp("sat_lane0", 48'h0, 48'hFFFF, 48'h7FFF, 1'b1);
    do_clr();
    chk("sat_flag_clr", {47'h0, sat1}, 48'h0);

    // Swap in the same cycle as an activation uses the old weight
    load_w(16'h0003);
    do_clr();
    top = 48'h5; wgt_ld = 1'b1;
    tick();
    wgt_ld = 1'b0; top = '0;
    act_vld = 1'b1; left = 8'd2; swap = 1'b1;
    tick();
    swap = 1'b0;
    acts(8'd2, 1);
    drain_exp("swap_flight", 48'h0, 48'hFFFFFF, 48'd16, 1'b0);

    // Load and swap together: active takes the old shadow
    load_w(16'h0003);
    top = 48'h5; wgt_ld = 1'b1;
    tick();
    top = 48'h7; swap = 1'b1;
    tick();
    wgt_ld = 1'b0; swap = 1'b0; top = '0;
    do_clr();
    acts(8'd1, 1);
    swap = 1'b1;
    tick();
    swap = 1'b0;
    acts(8'd1, 1);
    drain_exp("ld_swap", 48'h0, 48'hFFFFFF, 48'd12, 1'b0);

    // Drain chain
    do_clr();
    drain_exp("chain0", 48'h000007_000003, {48{1'b1}}, 48'h0, 1'b0);
    drain_exp("chain1", 48'h000002_000001, {48{1'b1}}, 48'h000007_000003, 1'b0);
    drain_exp("chain2", 48'h0, {48{1'b1}}, 48'h000002_000001, 1'b0);

    // Async reset between edges mid-accumulate
    load_w(16'h007F);
    do_clr();
    act_vld = 1'b1; left = 8'd127;
    repeat (3) tick();
    act_vld = 1'b0; left = 8'h55; top = 48'h123456;
    tick();
    tick();
    chk("pre_rst_sat", {47'h0, sat1}, 48'h1);
    chk("pre_rst_bot", bot0, 48'h123456);
    #2 rst = 1'b1;
    #1;
    chk("arst_bottom", bot0, 48'h0);
    chk("arst_right", {40'h0, right0}, 48'h0);
    chk("arst_sat", {47'h0, sat1}, 48'h0);
    #1 rst = 1'b0;
    left = '0;
    drain_exp("post_rst_drain", 48'h0, {48{1'b1}}, 48'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_stg_gen.md
Name: pe_stg_gen

Overview:
Parametrised weight-stationary systolic-array PE, successor to the fixed two-lane int8 PE.
- One activation per cycle is multiplied against LANES packed, double-buffered weights, accumulating into LANES saturating accumulators.
- Accumulators drain through a vertical shift chain.
- A floating-point normalization mode (generic EXP_W/MAN_W) is retained.
- Instances tile into an R x C array: activations flow left to right, weights, partial sums and normalization data flow top to bottom.

Parameters:
ACT_W, 8, activation width (signed)
WGT_W, 8, weight width per lane (signed)
LANES, 2, packed weights and accumulators per PE
ACC_W, 24, accumulator width per lane (signed)
TOP_W, 48, vertical bus width; must be >= LANES*ACC_W, >= 2*MAN_W+EXP_W and a multiple of LANES*WGT_W
EXP_W, 8, normalization exponent width
MAN_W, 8, normalized mantissa width, sign included

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
mode_sel_in  in  2  00 matmul, 01 bypass, 10 fp normalize, 11 treated as bypass
act_vld_in  in  1  left_in valid
left_in  in  ACT_W  activation
right_out  out  ACT_W  registered activation to the east neighbour
act_vld_out  out  1  registered act_vld_in
wgt_ld_in  in  1  write shadow weights from the selected top_in slot
wgt_sel_in  in  clog2(TOP_W/(LANES*WGT_W)) (min 1)  top_in slot index, slot width LANES*WGT_W
wgt_swap_in  in  1  copy shadow weights to active weights
clr_in  in  1  zero accumulators and sat_flag_out
drain_in  in  1  shift accumulators out and load them from top_in
top_in  in  TOP_W  vertical input
bottom_out  out  TOP_W  vertical output (registered)
sat_flag_out  out  1  sticky: any lane saturated since the last clr_in or rst

Behaviour:
- Reset: rst asynchronously zeroes right_out, act_vld_out, bottom_out, sat_flag_out, all accumulators, shadow and active weights, and the M-stage. No other register needs reset.
- East path: right_out <= left_in and act_vld_out <= act_vld_in every cycle, in all modes. Latency 1.
- Weights:
  - wgt_ld_in: shadow[i] <= top_in[slot*LANES*WGT_W + i*WGT_W +: WGT_W].
  - wgt_swap_in: active <= shadow. If load and swap fire in the same cycle, active takes the old shadow and shadow takes the new slot.
- M-stage (mode 00 only): when act_vld_in is high, prod[i] <= left_in * active[i] (signed, ACT_W+WGT_W bits) and m_vld <= 1; otherwise m_vld <= 0. The active weights are sampled in the same cycle as the activation, so a swap affects only later activations.
- Accumulate: acc[i] <= sat(acc[i] + sext(prod[i])) when m_vld. Latency from left_in to the acc update is 2 cycles.
- Saturation: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set sat_flag_out.
- Accumulator priority: rst > clr_in > drain_in > accumulate.
  - drain_in: acc[i] <= top_in[i*ACC_W +: ACC_W]. An m_vld product in the same cycle is discarded; the controller keeps 2 idle cycles before drain.
  - clr_in together with an m_vld product: the product is discarded.
- bottom_out priority:
  - drain_in: bottom_out <= zero-extended {acc[LANES-1],...,acc[0]}, the pre-update values.
  - else mode 00 or 01/11: bottom_out <= top_in.
  - else mode 10: bottom_out <= zero-extended {man_sm[MAN_W-1], exp, man_sm[MAN_W-2:0]}.
- Bypass modes 01/11: accumulators hold.
- Normalize (mode 10, 1-cycle latency), with P = top_in[2*MAN_W-1:0] (signed product) and E = top_in[2*MAN_W +: EXP_W]:
  - flag = P[2MAN_W-1] ^ P[2MAN_W-2].
  - flag: man = P[2MAN_W-1 -: MAN_W], exp = E+1 (wraps modulo 2^EXP_W).
  - no flag: man = P[2MAN_W-2 -: MAN_W], exp = E.
  - Convert man to sign-magnitude; the most-negative value saturates to magnitude 2^(MAN_W-1)-1 with sign 1.

Decomposition:
- Package pe_stg_gen_pkg: mode enum (MODE_MM, MODE_BYP, MODE_NORM), sat_add function, sign-magnitude conversion function.
- Sub-module pe_fp_norm (combinational normalize plus sign-magnitude conversion, parameters EXP_W and MAN_W). Its output register stays in pe_stg_gen.

Test Plan:
- Basic matmul: top_in[15:0]=16'hFD05, wgt_sel_in=0, wgt_ld_in then wgt_swap_in; 3 valid acts of 4, wait 2, drain -> bottom_out[23:0]=24'd60, bottom_out[47:24]=24'hFFFFDC.
- Saturation (ACC_W=16, TOP_W=32): w0=127, act=127 x3 -> lane0 drains 16'h7FFF and sat_flag_out=1; clr_in -> sat_flag_out=0.
- Drain chain: accs {7,3}, drain with top_in=48'h000002_000001 -> bottom_out=48'h000007_000003; second drain -> bottom_out=48'h000002_000001.
- Normalize: E=8'h80, P=16'h4000 -> bottom_out[15:0]=16'h40C0; P=16'h2000 -> 16'h4040; P=16'hC000 -> sign 1, exp 8'h80, mag 7'h7F = 16'hC07F.
- Swap in flight: act 2 with w0=3 in the same cycle as swap to w0=5, then act 2 -> acc0=6+10=16.
- Async reset mid-accumulate: pulse rst between edges -> bottom_out, right_out and sat_flag_out read 0 immediately; a drain after release outputs 0.
